// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response and decode handshake bundle.
// The master side is the fetch stage; the slave side is memory plus decode.
interface instr_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a synchronous clear.
module fetch_fifo import fetch_pkg::*; #(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output T                         o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request at a time, responses buffered for decode.
// Optional macro FETCH_ALIGN_CHECK_EN turns misaligned PCs into faulting NOP entries.
module instr_fetch import fetch_pkg::*; #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          i_pc_in,
  output logic                 o_pc_stall,
  input  logic                 i_flush,
  instr_fetch_if.master        bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  r_state;
  fetch_state_t  w_next_state;
  logic [31:0]   r_out_pc;

  logic          w_outstanding;
  logic          w_has_space;
  logic          w_misaligned;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_push;
  logic          w_fault_push;
  logic          w_id_valid;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned = (i_pc_in[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_outstanding = (r_state == WAIT_RSP);
  assign w_has_space   = !w_fifo_full &&
                         ((w_fifo_count + CW'(w_outstanding)) < CW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_out_pc <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_req_fire) begin
        r_out_pc <= {i_pc_in[31:2], 2'b00};
      end
    end
  end

  // Flush suppresses any request or push this cycle; reset masks every handshake.
  always_comb begin
    w_next_state = r_state;
    w_req_valid  = 1'b0;
    w_rsp_push   = 1'b0;
    w_fault_push = 1'b0;
    unique case (r_state)
      IDLE: w_next_state = ISSUE;
      ISSUE: begin
        if (!i_flush && w_has_space) begin
          if (w_misaligned) begin
            w_fault_push = 1'b1;
          end else begin
            w_req_valid = 1'b1;
            if (bus.imem_req_ready) begin
              w_next_state = WAIT_RSP;
            end
          end
        end
      end
      WAIT_RSP: begin
        if (bus.imem_rsp_valid) begin
          w_rsp_push   = !i_flush;
          w_next_state = ISSUE;
        end else if (i_flush) begin
          w_next_state = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.imem_rsp_valid) begin
          w_next_state = ISSUE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (reset) begin
      w_req_valid  = 1'b0;
      w_rsp_push   = 1'b0;
      w_fault_push = 1'b0;
    end
  end

  assign w_req_fire         = w_req_valid && bus.imem_req_ready;
  assign o_pc_stall         = !(w_req_fire || w_fault_push);
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = w_req_valid ? {i_pc_in[31:2], 2'b00} : 32'h0;

  always_comb begin
    w_push_entry = '{pc: r_out_pc, instr: bus.imem_rsp_data, fault: 1'b0};
    if (w_fault_push) begin
      w_push_entry = '{pc: i_pc_in, instr: NOP_INSTR, fault: 1'b1};
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .i_clear (reset || i_flush),
    .i_push  (w_rsp_push || w_fault_push),
    .i_data  (w_push_entry),
    .i_pop   (w_id_valid && bus.id_ready),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count),
    .o_head  (w_head)
  );

  assign w_id_valid   = !w_fifo_empty && !reset;
  assign bus.id_valid = w_id_valid;
  assign bus.id_instr = w_id_valid ? w_head.instr : NOP_INSTR;
  assign bus.id_pc    = w_id_valid ? w_head.pc : 32'h0;

`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.id_fault = w_id_valid && w_head.fault;
`else
  logic w_unused_fault;
  assign w_unused_fault = w_head.fault;
  assign bus.id_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scenarios plus a randomized run checked against a PC-stream reference model.
module tb_instr_fetch;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcIn;
  logic        pcStall;
  logic        flush;

  instr_fetch_if bus();

  instr_fetch #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_pc_in    (pcIn),
    .o_pc_stall (pcStall),
    .i_flush    (flush),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  logic [31:0] pcReg, expPc, memAddr, prevAddr, rspData, inFlight;
  bit          memBusy, prevPending, flNow, rdy, idRdy, rspNow, fire;
  int          memLat, popCount, idleGap;

  // The instruction word memory returns for any address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h0019_660D) + 32'h3C6E_F35F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then let outputs settle.
  task automatic applyStimulus(input logic rst, input logic fl, input logic [31:0] pc,
                               input logic reqRdy, input logic rspV,
                               input logic [31:0] rspD, input logic idReady);
    @(posedge clk);
    #1;
    reset              = rst;
    flush              = fl;
    pcIn               = pc;
    bus.imem_req_ready = reqRdy;
    bus.imem_rsp_valid = rspV;
    bus.imem_rsp_data  = rspD;
    bus.id_ready       = idReady;
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".pcStall"},  32'(pcStall),            32'd1);
    checkOutput({tag, ".reqValid"}, 32'(bus.imem_req_valid), 32'd0);
    checkOutput({tag, ".reqAddr"},  bus.imem_req_addr,       32'd0);
    checkOutput({tag, ".idValid"},  32'(bus.id_valid),       32'd0);
    checkOutput({tag, ".idInstr"},  bus.id_instr,            NOP);
    checkOutput({tag, ".idPc"},     bus.id_pc,               32'd0);
    checkOutput({tag, ".idFault"},  32'(bus.id_fault),       32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; pcIn = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0; bus.id_ready = 1'b0;

    // Reset, first fetch and first decode entry.
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 0);
    checkResetValues("reset");
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 0);
    checkOutput("firstIdle.reqValid", 32'(bus.imem_req_valid), 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 0);
    checkOutput("first.reqValid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("first.reqAddr",  bus.imem_req_addr,       32'h0);
    checkOutput("first.pcStall",  32'(pcStall),            32'd0);
    applyStimulus(0, 0, 32'h4, 1, 1, 32'h0010_0093, 0);
    checkOutput("waitRsp.pcStall", 32'(pcStall),      32'd1);
    checkOutput("waitRsp.idValid", 32'(bus.id_valid), 32'd0);
    applyStimulus(0, 0, 32'h4, 1, 0, 32'h0, 0);
    checkOutput("first.idValid", 32'(bus.id_valid), 32'd1);
    checkOutput("first.idPc",    bus.id_pc,         32'h0);
    checkOutput("first.idInstr", bus.id_instr,      32'h0010_0093);
    checkOutput("second.reqAddr", bus.imem_req_addr, 32'h4);
    applyStimulus(0, 0, 32'h8, 1, 1, 32'h0020_0113, 0);

    // Full FIFO blocks further requests until decode drains it.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 32'h8, 1, 0, 32'h0, 0);
      checkOutput("full.reqValid", 32'(bus.imem_req_valid), 32'd0);
      checkOutput("full.pcStall",  32'(pcStall),            32'd1);
    end
    applyStimulus(0, 0, 32'h8, 0, 0, 32'h0, 1);
    checkOutput("drain0.idPc", bus.id_pc, 32'h0);
    applyStimulus(0, 0, 32'h8, 0, 0, 32'h0, 1);
    checkOutput("drain1.idPc",    bus.id_pc,    32'h4);
    checkOutput("drain1.idInstr", bus.id_instr, 32'h0020_0113);

    // Request held while memory is not ready.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) applyStimulus(0, 0, 32'h8, 0, 0, 32'h0, 1);
      checkOutput("hold.reqValid", 32'(bus.imem_req_valid), 32'd1);
      checkOutput("hold.reqAddr",  bus.imem_req_addr,       32'h8);
      checkOutput("hold.pcStall",  32'(pcStall),            32'd1);
    end
    applyStimulus(0, 0, 32'h8, 1, 0, 32'h0, 1);
    checkOutput("accept.pcStall", 32'(pcStall), 32'd0);

    // Flush while waiting: the late response is dropped.
    applyStimulus(0, 1, 32'hC, 1, 0, 32'h0, 0);
    checkOutput("flush.reqValid", 32'(bus.imem_req_valid), 32'd0);
    applyStimulus(0, 0, 32'h100, 1, 0, 32'h0, 0);
    checkOutput("discard.reqValid", 32'(bus.imem_req_valid), 32'd0);
    applyStimulus(0, 0, 32'h100, 1, 1, 32'hDEAD_BEEF, 0);
    applyStimulus(0, 0, 32'h100, 1, 0, 32'h0, 0);
    checkOutput("dropped.idValid",   32'(bus.id_valid),       32'd0);
    checkOutput("redirect.reqValid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("redirect.reqAddr",  bus.imem_req_addr,       32'h100);

    // Reset while waiting; a stale response after release is ignored.
    applyStimulus(1, 0, 32'h104, 1, 0, 32'h0, 0);
    checkOutput("midReset.reqValid", 32'(bus.imem_req_valid), 32'd0);
    applyStimulus(0, 0, 32'h104, 1, 1, 32'h1234_5678, 1);
    checkResetValues("staleRsp");
    applyStimulus(0, 0, 32'h104, 0, 0, 32'h0, 1);
    checkOutput("staleRsp.idValidLater", 32'(bus.id_valid), 32'd0);

`ifdef FETCH_ALIGN_CHECK_EN
    applyStimulus(1, 0, 32'h6, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h6, 1, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h6, 1, 0, 32'h0, 0);
    checkOutput("align.reqValid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("align.pcStall",  32'(pcStall),            32'd0);
    applyStimulus(0, 0, 32'h8, 0, 0, 32'h0, 0);
    checkOutput("align.idValid", 32'(bus.id_valid), 32'd1);
    checkOutput("align.idFault", 32'(bus.id_fault), 32'd1);
    checkOutput("align.idInstr", bus.id_instr,      32'h0000_0013);
    checkOutput("align.idPc",    bus.id_pc,         32'h6);
`endif

    // Randomized run: decode must see the PC stream since the last redirect, in order.
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    pcReg = '0; expPc = '0; memAddr = '0; prevAddr = '0;
    memBusy = 0; prevPending = 0; memLat = 0; popCount = 0; idleGap = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flNow   = ($urandom_range(0, 24) == 0);
      rdy     = ($urandom_range(0, 3) != 0);
      idRdy   = !flNow && ($urandom_range(0, 3) != 0);
      rspNow  = 0;
      rspData = $urandom;
      if (memBusy) begin
        if (memLat == 0) begin
          rspNow  = 1;
          rspData = memWord(memAddr);
          memBusy = 0;
        end else begin
          memLat--;
        end
      end
      applyStimulus(0, flNow, pcReg, rdy, rspNow, rspData, idRdy);

      inFlight = (pcReg - expPc) >> 2;
      if (flNow) checkOutput("rnd.reqInFlush", 32'(bus.imem_req_valid), 32'd0);
      if (prevPending && !flNow) begin
        checkOutput("rnd.reqHold",  32'(bus.imem_req_valid), 32'd1);
        checkOutput("rnd.addrHold", bus.imem_req_addr,       prevAddr);
      end
      if (inFlight >= FIFO_DEPTH) checkOutput("rnd.depthLimit", 32'(bus.imem_req_valid), 32'd0);

      if (bus.id_valid && idRdy) begin
        checkOutput("rnd.popAhead", 32'(expPc != pcReg), 32'd1);
        checkOutput("rnd.idPc",     bus.id_pc,           expPc);
        checkOutput("rnd.idInstr",  bus.id_instr,        memWord(expPc));
        expPc += 4;
        popCount++;
        idleGap = 0;
      end else begin
        idleGap++;
        if (idleGap >= 80) begin
          checkOutput("rnd.progressGap", 32'(idleGap), 32'd0);
          idleGap = 0;
        end
      end
      if (!bus.id_valid) checkOutput("rnd.idleNop", bus.id_instr, NOP);

      fire = bus.imem_req_valid && rdy;
      checkOutput("rnd.pcStall", 32'(pcStall), 32'(!fire));
      if (fire) begin
        checkOutput("rnd.reqAddr",        bus.imem_req_addr,   pcReg);
        checkOutput("rnd.oneOutstanding", 32'(memBusy || rspNow), 32'd0);
        memBusy = 1;
        memAddr = pcReg;
        memLat  = $urandom_range(0, 2);
        pcReg  += 4;
      end
      prevPending = bus.imem_req_valid && !rdy;
      prevAddr    = bus.imem_req_addr;

      if (flNow) begin
        pcReg = $urandom & 32'hFFFF_FFFC;
        expPc = pcReg;
      end
    end
    checkOutput("rnd.enoughPops", 32'(popCount > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage between the program counter and the decode stage. It takes the current program counter, issues one instruction-memory read at a time over a valid/ready request port, and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake. It back-pressures the program counter through `pc_stall` and discards wrong-path work on `flush`.

## Interface
Parameters:
- FIFO_DEPTH, 2, number of buffered {pc, instr} entries; power of two, 2 to 8.
- NOP_INSTR, 32'h00000013, value driven on `id_instr` whenever `id_valid` is low.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- pc_in  in  32  current program counter.
- pc_stall  out  1  high = program counter must hold.
- flush  in  1  redirect from execute; kill all in-flight and buffered fetches.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid, one cycle per response, no back-pressure.
- imem_rsp_data  in  32  instruction word.
- id_valid  out  1  entry available to decode.
- id_ready  in  1  decode accepts the entry.
- id_instr  out  32  instruction.
- id_pc  out  32  PC of the instruction.
- id_fault  out  1  misaligned-PC marker; see Configuration.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, DISCARD.
- IDLE: entered on reset. Moves to ISSUE the next cycle.
- ISSUE: drives `imem_req_valid` when `count + outstanding < FIFO_DEPTH`, with `imem_req_addr = {pc_in[31:2], 2'b00}`.
  - On `imem_req_valid & imem_req_ready`: latch the PC into the outstanding register and go to WAIT_RSP.
- WAIT_RSP: on `imem_rsp_valid`, push {latched pc, data} and return to ISSUE.
  - At most one request is outstanding.
- DISCARD: entered when `flush` arrives in WAIT_RSP without a same-cycle response. The next `imem_rsp_valid` is dropped, then the FSM goes to ISSUE.
- Request stability: once `imem_req_valid` rises, it and `imem_req_addr` stay stable until accepted. Only `flush` or `reset` may withdraw them.
- `pc_stall` is low only in a cycle where `imem_req_valid & imem_req_ready`. It is high in every other cycle, including during reset.
- FIFO:
  - Pop on `id_valid & id_ready`.
  - Push and pop in the same cycle are legal when full.
  - A push is never attempted when full; this is guaranteed by the issue condition.
  - `id_instr` and `id_pc` come from the head entry. `id_instr = NOP_INSTR` when the FIFO is empty.
- Flush:
  - FIFO is cleared.
  - `imem_req_valid` is low in the flush cycle.
  - A response arriving in the flush cycle is dropped.
  - From ISSUE or IDLE, the FSM goes to ISSUE. From WAIT_RSP with no same-cycle response, it goes to DISCARD.
- `imem_rsp_valid` in IDLE or ISSUE (stale, e.g. after reset mid-operation) is ignored.

## Timing
- Reset values: `pc_stall = 1`, `imem_req_valid = 0`, `imem_req_addr = 0`, `id_valid = 0`, `id_instr = NOP_INSTR`, `id_pc = 0`, `id_fault = 0`. FSM = IDLE, FIFO empty, no outstanding request.
- First request: `imem_req_valid` rises 2 cycles after `reset` deasserts.
- Response: earliest one cycle after acceptance. `id_valid` rises the cycle after the response is pushed (registered FIFO output).
- Sustained throughput with zero-latency memory and `id_ready = 1`: one instruction every 2 cycles (single outstanding request).
- Flush takes effect at the edge ending the flush cycle. The first new request is issued the following cycle, from ISSUE.
- `reset` overrides `flush` and all handshakes.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - If `pc_in[1:0] != 0` in ISSUE, no memory request is made.
  - Instead, an entry {pc_in, NOP_INSTR, fault = 1} is pushed directly if space exists.
  - `pc_stall` is low for that one cycle so the program counter advances.
  - `id_fault` shows the head entry's fault bit.
- FETCH_ALIGN_CHECK_EN undefined:
  - `pc_in[1:0]` is ignored (address is forced word-aligned).
  - No fault bit is stored and `id_fault` is tied 0.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum.
  - `fetch_entry_t` struct {pc, instr, fault}.
  - `NOP_INSTR_DEFAULT` constant.
- Sub-module `fetch_fifo`:
  - Parameterised by depth and entry type.
  - Ports: push, pop, clear, full, empty, count, head.
  - Synchronous clear used for flush and reset.
- `instr_fetch` holds the FSM, the outstanding PC register and the handshake logic.

## Test plan
- Reset release, `pc_in = 32'h0000_0000`, `imem_req_ready = 1`, response 1 cycle later with `32'h0010_0093`:
  - `imem_req_valid` rises 2 cycles after reset.
  - `pc_stall` is low for one cycle.
  - `id_valid` rises with `id_pc = 0` and `id_instr = 32'h0010_0093`.
- `id_ready = 0` with FIFO_DEPTH = 2: after 2 entries, `imem_req_valid` stays low and `pc_stall` stays high. Raising `id_ready` drains entries in order, PCs 0x0 then 0x4.
- `imem_req_ready` held low 3 cycles: `imem_req_valid` and `imem_req_addr = 32'h0000_0008` stay stable, and `pc_stall` stays high until acceptance.
- `flush` in WAIT_RSP, response 2 cycles later:
  - Response is dropped and `id_valid` stays 0.
  - Next request uses the new `pc_in = 32'h0000_0100`.
- Reset asserted in WAIT_RSP, then a response 1 cycle after release: ignored, and all outputs hold their reset values.
- With FETCH_ALIGN_CHECK_EN defined, `pc_in = 32'h0000_0006`: no memory request, `id_valid = 1`, `id_fault = 1`, `id_instr = 32'h0000_0013`.
